// File: rtl/exu_muldiv_pkg.sv
// Shared definitions for the RV32 M-extension unit: funct3 op codes, FSM states
// and operand-sign helpers.
package exu_muldiv_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int XLEN_DEF  = CPU_WIDTH;

  typedef enum logic [2:0] {
    EXU_MD_MUL    = 3'b000,
    EXU_MD_MULH   = 3'b001,
    EXU_MD_MULHSU = 3'b010,
    EXU_MD_MULHU  = 3'b011,
    EXU_MD_DIV    = 3'b100,
    EXU_MD_DIVU   = 3'b101,
    EXU_MD_REM    = 3'b110,
    EXU_MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic src1_signed(input md_op_e op);
    return (op == EXU_MD_MULH) || (op == EXU_MD_MULHSU) ||
           (op == EXU_MD_DIV)  || (op == EXU_MD_REM);
  endfunction

  function automatic logic src2_signed(input md_op_e op);
    return (op == EXU_MD_MULH) || (op == EXU_MD_DIV) || (op == EXU_MD_REM);
  endfunction

endpackage

// File: rtl/exu_muldiv_iter.sv
// One-bit-per-cycle unsigned datapath: shift-add multiply or restoring divide
// over a 2*XLEN accumulator. Operands arrive as magnitudes; signs handled by the parent.
module exu_muldiv_iter
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc_nxt,
  output logic              o_last
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_div;
  logic [CW-1:0]     r_cnt;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [2*XLEN-1:0] w_div_nxt;

  // Multiply: {hi, multiplier} -- add b into hi when lsb set, then shift right with carry.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
  assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

  // Divide: {rem, quotient} -- shift left, keep the trial subtraction when it does not borrow.
  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_div_nxt = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  assign o_acc_nxt = r_div ? w_div_nxt : w_mul_nxt;
  assign o_last    = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(XLEN - 1);
    end else if (i_step) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded before being read.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_acc <= {{XLEN{1'b0}}, i_a};
      r_b   <= i_b;
      r_div <= i_is_div;
    end else if (i_step) begin
      r_acc <= o_acc_nxt;
    end
  end

endmodule

// File: rtl/exu_muldiv.sv
// Multi-cycle RV32 M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
// with valid/ready request and result ports and an optional single-cycle multiplier.
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         r_state;
  md_op_e            r_op;
  logic [XLEN-1:0]   r_src1;
  logic [XLEN-1:0]   r_src2;
  logic              r_neg;

  md_op_e            w_op;
  logic              w_accept;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [2*XLEN-1:0] w_ext1;
  logic [2*XLEN-1:0] w_ext2;
  logic [2*XLEN-1:0] w_prod_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_s1;
  logic              w_s2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_last;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod_sgn;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign o_in_ready = (r_state == ST_IDLE);
  assign o_busy     = (r_state != ST_IDLE);

  assign w_op     = md_op_e'(i_op);
  assign w_accept = i_in_valid && o_in_ready;
  assign w_div0   = op_is_div(w_op) && (i_src2 == '0);
  assign w_ovf    = op_is_div(w_op) && src2_signed(w_op) && (i_src1 == MOST_NEG) && (&i_src2);
  assign w_fast   = (MUL_FAST && !op_is_div(w_op)) || w_div0 || w_ovf;

  // Sign-extended 2*XLEN product; the low 2*XLEN bits are correct for every mul flavour.
  assign w_ext1      = {{XLEN{src1_signed(w_op) && i_src1[XLEN-1]}}, i_src1};
  assign w_ext2      = {{XLEN{src2_signed(w_op) && i_src2[XLEN-1]}}, i_src2};
  assign w_prod_fast = w_ext1 * w_ext2;

  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    w_fast_res = w_prod_fast[XLEN-1:0];
    if (w_div0) begin
      w_fast_res = ((w_op == EXU_MD_DIV) || (w_op == EXU_MD_DIVU)) ? '1 : i_src1;
    end else if (w_ovf) begin
      w_fast_res = (w_op == EXU_MD_DIV) ? i_src1 : '0;
    end else if (w_op != EXU_MD_MUL) begin
      w_fast_res = w_prod_fast[2*XLEN-1:XLEN];
    end
  end

  assign w_s1   = src1_signed(r_op) && r_src1[XLEN-1];
  assign w_s2   = src2_signed(r_op) && r_src2[XLEN-1];
  assign w_mag1 = w_s1 ? -r_src1 : r_src1;
  assign w_mag2 = w_s2 ? -r_src2 : r_src2;

  exu_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_flush),
    .i_load    ((r_state == ST_PREP) && !i_flush),
    .i_step    ((r_state == ST_CALC) && !i_flush),
    .i_is_div  (op_is_div(r_op)),
    .i_a       (w_mag1),
    .i_b       (w_mag2),
    .o_acc_nxt (w_acc_nxt),
    .o_last    (w_last)
  );

  // Result fix-up on the final step: product negated over the full width, quotient/remainder separately.
  assign w_prod_sgn = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quo      = r_neg ? -w_acc_nxt[XLEN-1:0]      : w_acc_nxt[XLEN-1:0];
  assign w_rem      = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_final = w_rem;
    case (r_op)
      EXU_MD_MUL:                               w_final = w_prod_sgn[XLEN-1:0];
      EXU_MD_MULH, EXU_MD_MULHSU, EXU_MD_MULHU: w_final = w_prod_sgn[2*XLEN-1:XLEN];
      EXU_MD_DIV, EXU_MD_DIVU:                  w_final = w_quo;
      default:                                  w_final = w_rem;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_neg       <= 1'b0;
      o_out_valid <= 1'b0;
      o_result    <= '0;
    end else if (i_flush) begin
      r_state     <= ST_IDLE;
      o_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_in_valid) begin
          if (w_fast) begin
            r_state     <= ST_DONE;
            o_out_valid <= 1'b1;
            o_result    <= w_fast_res;
          end else begin
            r_state <= ST_PREP;
          end
        end
        ST_PREP: begin
          r_state <= ST_CALC;
          r_neg   <= (r_op == EXU_MD_REM) ? w_s1 : (w_s1 ^ w_s2);
        end
        ST_CALC: if (w_last) begin
          r_state     <= ST_DONE;
          o_out_valid <= 1'b1;
          o_result    <= w_final;
        end
        ST_DONE: if (i_out_ready) begin
          r_state     <= ST_IDLE;
          o_out_valid <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_op   <= w_op;
      r_src1 <= i_src1;
      r_src2 <= i_src2;
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
// Self-checking bench for exu_muldiv: iterative and fast-multiply instances,
// table-driven vectors through a scoreboard plus backpressure/flush/reset sequences.
module tb_exu_muldiv;
  import exu_muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        v0, v1;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        out_ready;
  logic        rdy0, ov0, busy0;
  logic        rdy1, ov1, busy1;
  logic [31:0] res0, res1;

  int n_checks = 0;
  int n_errors = 0;

  exu_muldiv #(.XLEN(32), .MUL_FAST(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(v0), .o_in_ready(rdy0), .i_op(op), .i_src1(src1), .i_src2(src2),
    .o_out_valid(ov0), .i_out_ready(out_ready), .o_result(res0), .o_busy(busy0)
  );

  exu_muldiv #(.XLEN(32), .MUL_FAST(1'b1)) dut_fast (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(v1), .o_in_ready(rdy1), .i_op(op), .i_src1(src1), .i_src2(src2),
    .o_out_valid(ov1), .i_out_ready(out_ready), .o_result(res1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          fast;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit f, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int l);
    vec_t v;
    v.fast = f; v.op = o; v.a = a; v.b = b; v.res = r; v.lat = l;
    vecs.push_back(v);
  endtask

  // Reference model built on native SV arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pa, pb, p;
    int sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    pa  = (o == EXU_MD_MULH || o == EXU_MD_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
    pb  = (o == EXU_MD_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p   = pa * pb;
    case (o)
      EXU_MD_MUL:  return p[31:0];
      EXU_MD_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      EXU_MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      EXU_MD_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      EXU_MD_REMU: return (b == 0) ? a : a % b;
      default:     return p[63:32];
    endcase
  endfunction

  function automatic int ref_lat(input bit f, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2])
      return ((b == 0) || ((o == EXU_MD_DIV || o == EXU_MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
    return f ? 1 : 34;
  endfunction

  // Call #1 after a rising edge; returns #1 after the handshake edge.
  task automatic run_op(input bit f, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int l, input string name);
    int g;
    int lat;
    exp_t e;
    g = 0;
    while (!(f ? rdy1 : rdy0) && g < 200) begin
      @(posedge clk); #1; g++;
    end
    check({name, " ready"}, {31'b0, (f ? rdy1 : rdy0)}, 32'd1);
    op = o; src1 = a; src2 = b;
    if (f) v1 = 1'b1; else v0 = 1'b1;
    e.res = r; e.lat = l; e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    lat = 1;
    while (!(f ? ov1 : ov0) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (sb_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check({e.name, " latency"}, 32'(lat), 32'(e.lat));
      check({e.name, " result"}, (f ? res1 : res0), e.res);
    end
    @(posedge clk); #1;
    check({name, " idle"}, {31'b0, (f ? rdy1 : rdy0)}, 32'd1);
  endtask

  task automatic abort_test(input bit use_rst, input string name);
    bit seen;
    op = EXU_MD_DIVU; src1 = 32'd1000; src2 = 32'd3; v0 = 1'b1;
    @(posedge clk); #1; v0 = 1'b0;           // PREP
    @(posedge clk); #1;                      // CALC cycle 0
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    check({name, " ready"}, {31'b0, rdy0}, 32'd1);
    check({name, " busy"}, {31'b0, busy0}, 32'd0);
    if (use_rst) check({name, " result cleared"}, res0, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov0) seen = 1'b1;
    end
    check({name, " valid never rose"}, {31'b0, seen}, 32'd0);
    run_op(1'b0, EXU_MD_DIVU, 32'd9, 32'd3, 32'd3, 34, {name, " divu 9/3"});
  endtask

  initial begin
    int lat;
    exp_t e;
    rst = 1'b1; flush = 1'b0; v0 = 1'b0; v1 = 1'b0;
    op = '0; src1 = '0; src2 = '0; out_ready = 1'b1;

    // Directed vectors: {fast, op, a, b, expected, latency}.
    add_vec(0, EXU_MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    add_vec(1, EXU_MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
    add_vec(0, EXU_MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    add_vec(1, EXU_MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
    add_vec(0, EXU_MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    add_vec(0, EXU_MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    add_vec(1, EXU_MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    add_vec(0, EXU_MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    add_vec(0, EXU_MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    add_vec(0, EXU_MD_DIVU,   32'd100,      32'd7,         32'd14,        34);
    add_vec(0, EXU_MD_REMU,   32'd100,      32'd7,         32'd2,         34);
    add_vec(0, EXU_MD_DIV,    32'd5,        32'd0,         32'hFFFF_FFFF, 1);
    add_vec(0, EXU_MD_REM,    32'd5,        32'd0,         32'd5,         1);
    add_vec(0, EXU_MD_DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF, 1);
    add_vec(0, EXU_MD_REMU,   32'd5,        32'd0,         32'd5,         1);
    add_vec(0, EXU_MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    add_vec(0, EXU_MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
    add_vec(1, EXU_MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    add_vec(0, EXU_MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         34);
    add_vec(0, EXU_MD_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 34);
    add_vec(0, EXU_MD_DIV,    32'h8000_0000, 32'd1,         32'h8000_0000, 34);
    add_vec(0, EXU_MD_REM,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34);
    add_vec(0, EXU_MD_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    add_vec(0, EXU_MD_MULHU,  32'h1234_5678, 32'd16,        32'h1,         34);
    add_vec(0, EXU_MD_REMU,   32'hFFFF_FFFF, 32'd16,        32'hF,         34);
    add_vec(1, EXU_MD_DIVU,   32'd9,        32'd3,         32'd3,         34);
    for (int k = 0; k < 8; k++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (k % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      add_vec(k[0], ro, ra, rb, ref_md(ro, ra, rb), ref_lat(k[0], ro, ra, rb));
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset in_ready", {31'b0, rdy0}, 32'd1);
    check("reset out_valid", {31'b0, ov0}, 32'd0);
    check("reset busy", {31'b0, busy0}, 32'd0);
    check("reset result", res0, 32'd0);
    check("reset fast in_ready", {31'b0, rdy1}, 32'd1);

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].fast, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat,
             $sformatf("vec%0d op%0d", i, vecs[i].op));

    // Backpressure: result held in DONE, pending request not taken until after the handshake.
    out_ready = 1'b0;
    op = EXU_MD_DIVU; src1 = 32'd100; src2 = 32'd7; v0 = 1'b1;
    e.res = 32'd14; e.lat = 34; e.name = "bp divu";
    sb_q.push_back(e);
    @(posedge clk); #1; v0 = 1'b0;
    lat = 1;
    while (!ov0 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e = sb_q.pop_front();
    check({e.name, " latency"}, 32'(lat), 32'(e.lat));
    op = EXU_MD_DIVU; src1 = 32'd9; src2 = 32'd3; v0 = 1'b1;
    e.res = 32'd3; e.lat = 34; e.name = "bp next divu";
    sb_q.push_back(e);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d result", c), res0, 32'd14);
      check($sformatf("bp hold%0d in_ready", c), {31'b0, rdy0}, 32'd0);
      check($sformatf("bp hold%0d valid", c), {31'b0, ov0}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release valid", {31'b0, ov0}, 32'd0);
    check("bp release in_ready", {31'b0, rdy0}, 32'd1);
    @(posedge clk); #1; v0 = 1'b0;
    check("bp next accept busy", {31'b0, busy0}, 32'd1);
    lat = 1;
    while (!ov0 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e = sb_q.pop_front();
    check({e.name, " latency"}, 32'(lat), 32'(e.lat));
    check({e.name, " result"}, res0, e.res);
    @(posedge clk); #1;

    // Flush in the same cycle as a request drops the request.
    op = EXU_MD_MUL; src1 = 32'd3; src2 = 32'd3; v0 = 1'b1; flush = 1'b1;
    @(posedge clk); #1; v0 = 1'b0; flush = 1'b0;
    check("flush+accept busy", {31'b0, busy0}, 32'd0);
    @(posedge clk); #1;
    check("flush+accept valid", {31'b0, ov0}, 32'd0);

    abort_test(1'b0, "flush");
    abort_test(1'b1, "reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
